denormalize: RTL and testbench

Inverse of the sensor-normalization stage. Takes one signed 8.8 fixed-point normalized value and the per-channel integer std and mean, and recovers the integer sensor value as trunc0(norm × std / 2^FRAC_W) + mean. It uses an iterative shift-add multiplier behind a valid/ready handshake. It sits after the classifier/regression path, where outputs must be mapped back to raw flex-sensor units.

---
 rtl/denorm_pkg.sv | 15 +
 rtl/shift_add_mul.sv | 48 ++++
 rtl/denormalize.sv | 121 ++++++++++++
 tb/tb_denormalize.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/denorm_pkg.sv
// Shared types and default widths for the denormalize block.
package denorm_pkg;

   localparam int DATA_W = 16;
   localparam int FRAC_W = 8;
   localparam int ITER_W = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      FIN,
      DONE
   } state_t;

endpackage

// File: rtl/shift_add_mul.sv
// Unsigned iterative shift-add multiplier: one multiplier bit (LSB-first) per step.
// start loads the operands and clears the accumulator; last flags the final step.
module shift_add_mul #(
   parameter int A_W    = 17,
   parameter int B_W    = 16,
   parameter int ITER_W = $clog2(B_W + 1)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic                 step,
   input  logic [A_W-1:0]       a,
   input  logic [B_W-1:0]       b,
   output logic [A_W+B_W-1:0]   product,
   output logic                 last,
   output logic                 done
);

   localparam int P_W = A_W + B_W;

   logic [P_W-1:0]    a_sh;
   logic [B_W-1:0]    b_sh;
   logic [ITER_W-1:0] cnt;

   assign done = (cnt == ITER_W'(B_W));
   assign last = (cnt == ITER_W'(B_W - 1));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         a_sh    <= '0;
         b_sh    <= '0;
         product <= '0;
         cnt     <= '0;
      end else if (start) begin
         a_sh    <= P_W'(a);
         b_sh    <= b;
         product <= '0;
         cnt     <= '0;
      end else if (step && !done) begin
         if (b_sh[0])
            product <= product + a_sh;
         a_sh <= a_sh << 1;
         b_sh <= b_sh >> 1;
         cnt  <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/denormalize.sv
// Recovers an integer sensor value: trunc0(norm * std / 2^FRAC_W) + mean.
// Define DENORMALIZE_SAT_EN to clamp the result to [0, 2^DATA_W-1]; otherwise it wraps.
module denormalize #(
   parameter int DATA_W = denorm_pkg::DATA_W,
   parameter int FRAC_W = denorm_pkg::FRAC_W
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [DATA_W-1:0] i_norm,
   input  logic [DATA_W-1:0] i_std,
   input  logic [DATA_W-1:0] i_mean,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [DATA_W-1:0] o_data
);

   import denorm_pkg::*;

   localparam int PROD_W = 2 * DATA_W + 1;
   localparam int R_W    = 2 * DATA_W + 2;
   localparam int CNT_W  = $clog2(DATA_W + 1);

   state_t              state;
   logic                sign;
   logic [DATA_W-1:0]   mean_q;
   logic [DATA_W:0]     norm_ext;
   logic [DATA_W:0]     mag_in;
   logic [PROD_W-1:0]   product;
   logic                mul_last;
   logic                mul_done;
   logic                start;
   logic [R_W-1:0]      q_mag;
   logic signed [R_W-1:0] q;
   logic signed [R_W-1:0] r;
   logic [DATA_W-1:0]   res;

   // One extra magnitude bit so -2^(DATA_W-1) maps to +2^(DATA_W-1).
   assign norm_ext = {i_norm[DATA_W-1], i_norm};
   assign mag_in   = i_norm[DATA_W-1] ? (~norm_ext + 1'b1) : norm_ext;

   assign o_ready = (state == IDLE);
   assign start   = (state == IDLE) && i_valid;

   shift_add_mul #(
      .A_W    (DATA_W + 1),
      .B_W    (DATA_W),
      .ITER_W (CNT_W)
   ) u_mul (
      .clk     (i_clk),
      .reset_n (i_reset_n),
      .start   (start),
      .step    (state == MUL),
      .a       (mag_in),
      .b       (i_std),
      .product (product),
      .last    (mul_last),
      .done    (mul_done)
   );

   // Shift the magnitude before applying the sign so the result truncates toward zero.
   assign q_mag = R_W'(product >> FRAC_W);
   assign q     = sign ? -signed'(q_mag) : signed'(q_mag);
   assign r     = q + signed'(R_W'(mean_q));

`ifdef DENORMALIZE_SAT_EN
   always_comb begin
      res = r[DATA_W-1:0];
      if (r[R_W-1])
         res = '0;
      else if (|r[R_W-2:DATA_W])
         res = '1;
   end
`else
   logic unused_hi;
   assign unused_hi = ^r[R_W-1:DATA_W];
   assign res       = r[DATA_W-1:0];
`endif

   logic unused_done;
   assign unused_done = mul_done;

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state   <= IDLE;
         sign    <= 1'b0;
         mean_q  <= '0;
         o_valid <= 1'b0;
         o_data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_valid) begin
                  sign   <= i_norm[DATA_W-1];
                  mean_q <= i_mean;
                  state  <= MUL;
               end
            end
            MUL: begin
               // The final shift-add lands on this same edge.
               if (mul_last)
                  state <= FIN;
            end
            FIN: begin
               o_data  <= res;
               o_valid <= 1'b1;
               state   <= DONE;
            end
            DONE: begin
               if (i_ready) begin
                  o_valid <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_denormalize.sv
// Scoreboard bench for denormalize: driver pushes expected results, a monitor checks them.
module tb_denormalize;

   logic        i_clk = 1'b0;
   logic        i_reset_n = 1'b0;
   logic        i_valid = 1'b0;
   logic        i_ready = 1'b1;
   logic [15:0] i_norm = '0;
   logic [15:0] i_std = '0;
   logic [15:0] i_mean = '0;
   logic        o_ready;
   logic        o_valid;
   logic [15:0] o_data;

   int checks = 0;
   int passes = 0;

   logic [15:0] exp_q[$];
   time         acc_q[$];
   bit          seen = 1'b0;

   always #5 i_clk = ~i_clk;

   denormalize dut (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_valid   (i_valid),
      .o_ready   (o_ready),
      .i_norm    (i_norm),
      .i_std     (i_std),
      .i_mean    (i_mean),
      .o_valid   (o_valid),
      .i_ready   (i_ready),
      .o_data    (o_data)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp)
         passes++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   task automatic fail(input string nm);
      checks++;
      $display("FAIL %s: bound expired", nm);
   endtask

   // Monitor: pop on the first cycle of each result; latency is 17 cycles + half period.
   always @(negedge i_clk) begin
      if (i_reset_n) begin
         chk("ready_valid_excl", {31'b0, o_ready & o_valid}, 32'd0);
         if (o_valid && !seen) begin
            seen = 1'b1;
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_out: got 0x%0h with empty scoreboard", o_data);
            end else begin
               logic [15:0] e;
               time t;
               e = exp_q.pop_front();
               t = acc_q.pop_front();
               chk("data", {16'b0, o_data}, {16'b0, e});
               chk("latency", 32'($time - t), 32'd175);
            end
         end
         if (!o_valid)
            seen = 1'b0;
      end else begin
         seen = 1'b0;
      end
   end

   task automatic send(input logic [15:0] n, input logic [15:0] s, input logic [15:0] m,
                       input logic [15:0] e);
      int w = 0;
      @(negedge i_clk);
      while (!o_ready && w < 100) begin
         @(negedge i_clk);
         w++;
      end
      if (!o_ready) fail("send_wait_ready");
      i_norm  = n;
      i_std   = s;
      i_mean  = m;
      i_valid = 1'b1;
      @(posedge i_clk);
      exp_q.push_back(e);
      acc_q.push_back($time);
      @(negedge i_clk);
      i_valid = 1'b0;
      i_norm  = 16'hDEAD;
      i_std   = 16'hBEEF;
      i_mean  = 16'h5A5A;
   endtask

   task automatic wait_done();
      int w = 0;
      while (!(exp_q.size() == 0 && o_ready) && w < 200) begin
         @(negedge i_clk);
         w++;
      end
      if (w >= 200) fail("wait_done");
   endtask

   initial begin
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      i_reset_n = 1'b1;
      @(negedge i_clk);
      chk("rst_ready", {31'b0, o_ready}, 32'd1);
      chk("rst_valid", {31'b0, o_valid}, 32'd0);
      chk("rst_data", {16'b0, o_data}, 32'd0);

      send(16'h0100, 16'd10, 16'd100, 16'd110);
      wait_done();
      send(16'hFF80, 16'd3, 16'd50, 16'd49);
      wait_done();
`ifdef DENORMALIZE_SAT_EN
      send(16'h8000, 16'd1000, 16'd0, 16'h0000);
      wait_done();
      send(16'h7FFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
`else
      send(16'h8000, 16'd1000, 16'd0, 16'h0C00);
      wait_done();
      send(16'h7FFF, 16'hFFFF, 16'hFFFF, 16'hFE7F);
`endif
      wait_done();
      send(16'h0300, 16'd0, 16'd1234, 16'd1234);
      wait_done();
      send(16'h0000, 16'd555, 16'd77, 16'd77);
      wait_done();

      // Backpressure: result must hold while i_valid pulses are ignored.
      i_ready = 1'b0;
      send(16'h0100, 16'd20, 16'd1, 16'd21);
      begin
         int w = 0;
         while (!o_valid && w < 50) begin
            @(negedge i_clk);
            w++;
         end
         if (!o_valid) fail("bp_wait_valid");
      end
      for (int i = 0; i < 5; i++) begin
         i_valid = 1'b1;
         i_norm  = 16'h0100 + 16'(i);
         i_std   = 16'd3;
         i_mean  = 16'd9;
         @(negedge i_clk);
         chk("bp_data", {16'b0, o_data}, 32'd21);
         chk("bp_ready", {31'b0, o_ready}, 32'd0);
         chk("bp_valid", {31'b0, o_valid}, 32'd1);
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      @(negedge i_clk);
      chk("bp_release_ready", {31'b0, o_ready}, 32'd1);
      chk("bp_release_valid", {31'b0, o_valid}, 32'd0);
      repeat (3) @(negedge i_clk);
      chk("bp_no_capture", {31'b0, o_ready}, 32'd1);

      // Reset lands on the edge that would perform MUL iteration 8.
      send(16'h0300, 16'd9, 16'd2, 16'd29);
      repeat (7) @(posedge i_clk);
      @(negedge i_clk);
      i_reset_n = 1'b0;
      exp_q.delete();
      acc_q.delete();
      @(negedge i_clk);
      i_reset_n = 1'b1;
      @(negedge i_clk);
      chk("mid_rst_valid", {31'b0, o_valid}, 32'd0);
      chk("mid_rst_data", {16'b0, o_data}, 32'd0);
      chk("mid_rst_ready", {31'b0, o_ready}, 32'd1);
      repeat (25) @(negedge i_clk);
      chk("mid_rst_idle", {31'b0, o_ready}, 32'd1);

      send(16'h0200, 16'd7, 16'd5, 16'd19);
      wait_done();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
